pwm_duty_decoder: RTL and testbench

- Receive side of the 3-bit PWM link: samples an incoming PWM waveform and measures high time and period in Clock cycles.
- Reports the recovered 3-bit duty code when the measured period matches the nominal frame length.
- Flags constant-level inputs (0 %/100 % duty) and off-frame periods.
- Sits downstream of the PWM generator output (or an external pin) in loopback/monitor designs.

---
 rtl/pwm_duty_decoder.sv | 145 ++++++++++++++
 tb/tb_pwm_duty_decoder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_decoder.sv
// PWM duty decoder: synchronises an asynchronous PWM input, measures high
// time and rise-to-rise period in clock cycles, recovers the duty code when
// the period matches the nominal frame, and flags stuck-low/stuck-high inputs.
module pwm_duty_decoder #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FRAME       = 8,
    parameter int DUTY_W      = 3,
    parameter int TIMEOUT     = 32
) (
    input  logic              Clock,
    input  logic              CLR_N,
    input  logic              PWM_IN,
    output logic [CNT_W-1:0]  HIGH_CNT,
    output logic [CNT_W-1:0]  PERIOD_CNT,
    output logic [DUTY_W-1:0] DUTY,
    output logic              DUTY_VALID,
    output logic              FRAME_ERR,
    output logic              STUCK_LOW,
    output logic              STUCK_HIGH
);

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] FRAME_C   = CNT_W'(FRAME);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t                 state;
    state_t                 next_state;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   s;
    logic                   s_d;
    logic                   rise;
    logic                   fall;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       high_len;
    logic                   fall_seen;
    logic                   do_meas;
    logic                   do_timeout;

    assign s    = sync_ff[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    // Bring the asynchronous input into the clock domain and keep one cycle of history for edge detection
    always_ff @(posedge Clock) begin
        if (!CLR_N) begin
            sync_ff <= '0;
            s_d     <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], PWM_IN};
            s_d     <= s;
        end
    end

    // Cycle counter restarted by each rise; captures high length on fall and remembers whether a fall occurred this period
    always_ff @(posedge Clock) begin
        if (!CLR_N) begin
            cnt       <= '0;
            high_len  <= '0;
            fall_seen <= 1'b0;
        end else begin
            if (rise) begin
                cnt <= CNT_W'(1);
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            if (fall) begin
                high_len <= cnt;
            end
            if (rise) begin
                fall_seen <= 1'b0;
            end else if (fall) begin
                fall_seen <= 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge Clock) begin
        if (!CLR_N) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: a rise always enters MEAS, completing a measurement only if a fall preceded it; timeout drops back to IDLE
    always_comb begin
        next_state = state;
        do_meas    = 1'b0;
        do_timeout = 1'b0;
        if (rise) begin
            next_state = MEAS;
            if (state == MEAS && fall_seen) begin
                do_meas = 1'b1;
            end
        end else if (cnt == TIMEOUT_C) begin
            do_timeout = 1'b1;
            next_state = IDLE;
        end
    end

    // Measurement and status outputs; they hold between strobes and stuck flags clear on the next rise
    always_ff @(posedge Clock) begin
        if (!CLR_N) begin
            HIGH_CNT   <= '0;
            PERIOD_CNT <= '0;
            DUTY       <= '0;
            DUTY_VALID <= 1'b0;
            FRAME_ERR  <= 1'b0;
            STUCK_LOW  <= 1'b0;
            STUCK_HIGH <= 1'b0;
        end else begin
            DUTY_VALID <= do_meas;
            if (do_meas) begin
                PERIOD_CNT <= cnt;
                HIGH_CNT   <= high_len;
                FRAME_ERR  <= (cnt != FRAME_C);
                if (cnt == FRAME_C) begin
                    DUTY <= high_len[DUTY_W-1:0];
                end
            end
            if (rise) begin
                STUCK_LOW  <= 1'b0;
                STUCK_HIGH <= 1'b0;
            end else if (do_timeout) begin
                if (s) begin
                    STUCK_HIGH <= 1'b1;
                    STUCK_LOW  <= 1'b0;
                    DUTY       <= '1;
                end else begin
                    STUCK_LOW  <= 1'b1;
                    STUCK_HIGH <= 1'b0;
                    DUTY       <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed self-checking bench for pwm_duty_decoder: frame sweeps, off-frame
// periods, stuck-low/stuck-high timeouts and mid-period reset.
module tb_pwm_duty_decoder;

    logic       clk;
    logic       clr_n;
    logic       pwm_in;
    logic [7:0] high_cnt;
    logic [7:0] period_cnt;
    logic [2:0] duty;
    logic       duty_valid;
    logic       frame_err;
    logic       stuck_low;
    logic       stuck_high;

    int tests_run;
    int tests_failed;
    int cyc;
    int rise_cyc;
    int sl_c0;
    int sh_c0;
    int sl_rise_cyc;
    int sh_rise_cyc;
    logic double_strobe;
    logic both_stuck;
    logic prev_valid;
    logic prev_sl;
    logic prev_sh;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];

    pwm_duty_decoder #(
        .CNT_W(8), .SYNC_STAGES(2), .FRAME(8), .DUTY_W(3), .TIMEOUT(32)
    ) dut (
        .Clock(clk),
        .CLR_N(clr_n),
        .PWM_IN(pwm_in),
        .HIGH_CNT(high_cnt),
        .PERIOD_CNT(period_cnt),
        .DUTY(duty),
        .DUTY_VALID(duty_valid),
        .FRAME_ERR(frame_err),
        .STUCK_LOW(stuck_low),
        .STUCK_HIGH(stuck_high)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter used to time stuck-flag assertion
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: records every strobe and watches strobe width and stuck-flag behaviour
    initial begin
        double_strobe = 1'b0;
        both_stuck    = 1'b0;
        prev_valid    = 1'b0;
        prev_sl       = 1'b0;
        prev_sh       = 1'b0;
        sl_rise_cyc   = -1;
        sh_rise_cyc   = -1;
        forever begin
            @(posedge clk);
            #1;
            if (duty_valid) got_q.push_back({12'd0, high_cnt, period_cnt, duty, frame_err});
            if (duty_valid && prev_valid) double_strobe = 1'b1;
            if (stuck_low && stuck_high) both_stuck = 1'b1;
            if (stuck_low && !prev_sl) sl_rise_cyc = cyc;
            if (stuck_high && !prev_sh) sh_rise_cyc = cyc;
            prev_valid = duty_valid;
            prev_sl    = stuck_low;
            prev_sh    = stuck_high;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One PWM frame: h cycles high then l cycles low
    task automatic applyStimulus(input int h, input int l);
        for (int i = 0; i < h; i++) begin
            tick();
            if (i == 0) rise_cyc = cyc;
            pwm_in = 1'b1;
        end
        for (int i = 0; i < l; i++) begin
            tick();
            pwm_in = 1'b0;
        end
    endtask

    task automatic expectStrobe(input int h, input int p, input int d, input int e);
        exp_q.push_back({12'd0, 8'(h), 8'(p), 3'(d), 1'(e)});
    endtask

    function automatic logic [31:0] outVec();
        return {9'd0, high_cnt, period_cnt, duty, duty_valid, frame_err, stuck_low, stuck_high};
    endfunction

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        clr_n        = 1'b0;
        pwm_in       = 1'b0;
        repeat (3) tick();
        checkOutput("reset_outputs", outVec(), 32'd0);
        clr_n = 1'b1;

        // Nominal 3/5 frames, then duty sweep, then two 10-cycle off-frame periods
        applyStimulus(3, 5); expectStrobe(3, 8, 3, 0);
        applyStimulus(3, 5); expectStrobe(3, 8, 3, 0);
        for (int d = 1; d < 8; d++) begin
            for (int r = 0; r < 3; r++) begin
                applyStimulus(d, 8 - d);
                expectStrobe(d, 8, d, 0);
            end
        end
        applyStimulus(4, 6); expectStrobe(4, 10, 7, 1);
        applyStimulus(4, 6); expectStrobe(4, 10, 7, 1);

        // Input goes low and stays low
        applyStimulus(3, 40);
        sl_c0 = rise_cyc;
        checkOutput("stuck_low_set", 32'(stuck_low), 32'd1);
        checkOutput("stuck_high_clear_a", 32'(stuck_high), 32'd0);
        checkOutput("duty_stuck_low", 32'(duty), 32'd0);
        checkOutput("strobes_before_stuck", 32'(got_q.size()), 32'd25);
        checkOutput("stuck_low_timing", 32'(sl_rise_cyc), 32'(sl_c0 + 35));

        // Recovery from stuck low: first rise is not a measurement
        applyStimulus(5, 3);
        checkOutput("stuck_low_cleared", 32'(stuck_low), 32'd0);
        applyStimulus(2, 6); expectStrobe(5, 8, 5, 0);

        // Input held high long enough to time out, then released
        applyStimulus(40, 4); expectStrobe(2, 8, 2, 0);
        sh_c0 = rise_cyc;
        checkOutput("stuck_high_set", 32'(stuck_high), 32'd1);
        checkOutput("stuck_low_clear_b", 32'(stuck_low), 32'd0);
        checkOutput("duty_stuck_high", 32'(duty), 32'd7);
        checkOutput("stuck_high_timing", 32'(sh_rise_cyc), 32'(sh_c0 + 35));
        applyStimulus(6, 2);
        checkOutput("stuck_high_cleared", 32'(stuck_high), 32'd0);
        checkOutput("no_strobe_from_idle", 32'(got_q.size()), 32'd27);
        applyStimulus(1, 7); expectStrobe(6, 8, 6, 0);

        // Reset in the middle of a high phase
        for (int i = 0; i < 6; i++) begin
            tick();
            pwm_in = 1'b1;
        end
        expectStrobe(1, 8, 1, 0);
        tick();
        clr_n = 1'b0;
        tick();
        clr_n = 1'b1;
        checkOutput("midperiod_reset_outputs", outVec(), 32'd0);
        applyStimulus(1, 6);
        applyStimulus(4, 4); expectStrobe(2, 8, 2, 0);
        applyStimulus(4, 4); expectStrobe(4, 8, 4, 0);
        applyStimulus(3, 5); expectStrobe(4, 8, 4, 0);
        repeat (4) tick();

        checkOutput("strobe_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            checkOutput($sformatf("strobe_%0d", i),
                        (i < got_q.size()) ? got_q[i] : 32'hFFFF_FFFF, exp_q[i]);
        end
        checkOutput("strobe_single_cycle", 32'(double_strobe), 32'd0);
        checkOutput("stuck_exclusive", 32'(both_stuck), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
